// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues tagged, word-aligned imem reads and queues {pc, instr} toward IF/ID.
// Latency: accept at cycle N, memory response at N+1, id_valid at N+2 (no FIFO bypass).
// Backpressure: credits cap requests outstanding plus buffered at DEPTH; id_ready=0 stalls fetch.

// Small circular FIFO with synchronous clear; the caller never pushes when full or pops when empty.
// Latency: a push at a posedge is visible at head_dat after that edge.
// Backpressure: none internally; push/pop are gated defensively on full/empty.
module if_fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_vld & (count != FULL);
    assign do_pop   = pop_rdy & (count != '0);
    assign head_dat = mem[rd_ptr];

    // Entry storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; clear empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// Fetch unit top: PC tag queue, instruction FIFO, outstanding/drop counters and RUN/DRAIN FSM.
// Latency: 2 cycles from request accept to id_valid with a 1-cycle memory.
// Backpressure: imem_req_valid drops once outstanding + buffered reaches DEPTH or during flush/drain.
module if_fetch_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [0:0]        state;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  drop_next;
    logic [CNT_W-1:0]  tag_cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [XLEN-1:0]   tag_head;
    logic [2*XLEN-1:0] fifo_head;
    logic [CNT_W:0]    inflight;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_hit;
    logic              rsp_take;
    logic              id_pop;

    // A response with nothing outstanding has no tag (protocol error or pre-reset leftover).
    assign rsp_hit   = imem_rsp_valid & (outstanding != '0);
    assign rsp_take  = rsp_hit & (state == ST_RUN) & !flush & (tag_cnt != '0);
    assign drop_next = outstanding - CNT_W'(rsp_hit);

    assign inflight       = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign credit_ok      = inflight < DEPTH_C;
    assign imem_req_valid = !rst & (state == ST_RUN) & !flush & credit_ok;
    assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_advance     = req_fire;

    // A flush wins over a simultaneous IF/ID pop; the FIFO is cleared instead.
    assign id_valid = (fifo_cnt != '0);
    assign id_pop   = id_valid & id_ready & !flush;
    assign id_pc    = id_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
    assign id_instr = id_valid ? fifo_head[XLEN-1:0] : '0;

    // PC tags of requests awaiting their response, in issue order.
    if_fetch_fifo #(
        .W     (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (req_fire),
        .push_dat (fetch_pc),
        .pop_rdy  (rsp_take),
        .head_dat (tag_head),
        .count    (tag_cnt)
    );

    // Returned instructions paired with their unmodified fetch PC.
    if_fetch_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_instr_q (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (rsp_take),
        .push_dat ({tag_head, imem_rsp_data}),
        .pop_rdy  (id_pop),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

    // Outstanding count tracks every accepted request until its response arrives, even when dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_hit);
        end
    end

    // RUN/DRAIN control: a flush arms the drop counter, DRAIN discards responses until it empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? ST_DRAIN : ST_RUN;
        end else if (state == ST_DRAIN) begin
            if (drop_cnt == '0) begin
                state <= ST_RUN;
            end else if (rsp_hit) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
                if (drop_cnt == CNT_W'(1)) begin
                    state <= ST_RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table plus hand-written flush/stall/reset sequences.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
// Memory responses and IF/ID ready are driven explicitly by each vector.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [31:0] pc;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_rv;
        logic        e_adv;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs [17];

    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0040_0093;
    localparam logic [31:0] W2 = 32'h0080_0113;
    localparam logic [31:0] W3 = 32'h00C0_0193;
    localparam logic [31:0] W4 = 32'h0010_0073;
    localparam logic [31:0] W5 = 32'hDEAD_BEEF;
    localparam logic [31:0] W6 = 32'h1111_2222;

    if_fetch_unit #(
        .XLEN  (32),
        .DEPTH (2),
        .CNT_W (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pc_advance     (pc_advance),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] pc,
                                input logic rr, input logic rv, input logic [31:0] rd,
                                input logic ir, input logic e_rv, input logic e_adv,
                                input logic [31:0] e_addr, input logic e_idv,
                                input logic [31:0] e_pc, input logic [31:0] e_ins);
        vec_t v;
        v.rst = r; v.flush = f; v.pc = pc; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
        v.e_rv = e_rv; v.e_adv = e_adv; v.e_addr = e_addr;
        v.e_idv = e_idv; v.e_pc = e_pc; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rv, input logic e_adv,
                           input logic [31:0] e_addr, input logic e_idv,
                           input logic [31:0] e_pc, input logic [31:0] e_ins);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
        chk({tag, ".pc_advance"}, {31'd0, pc_advance}, {31'd0, e_adv});
        chk({tag, ".req_addr"}, imem_req_addr, e_addr);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_idv});
        chk({tag, ".id_pc"}, id_pc, e_pc);
        chk({tag, ".id_instr"}, id_instr, e_ins);
    endtask

    task automatic drive(input logic r, input logic f, input logic [31:0] pc, input logic rr,
                         input logic rv, input logic [31:0] rd, input logic ir);
        rst = r; flush = f; fetch_pc = pc; imem_req_ready = rr;
        imem_rsp_valid = rv; imem_rsp_data = rd; id_ready = ir;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst flush  pc      rr rv rd   ir | req adv addr    idv id_pc   id_instr
        vecs[0]  = mk(1, 0, 32'h00, 1, 0, 0,  1,  0, 0, 32'h00, 0, 32'h00, 0);
        vecs[1]  = mk(0, 0, 32'h00, 1, 0, 0,  1,  1, 1, 32'h00, 0, 32'h00, 0);
        vecs[2]  = mk(0, 0, 32'h04, 1, 1, W0, 1,  1, 1, 32'h04, 0, 32'h00, 0);
        vecs[3]  = mk(0, 0, 32'h08, 1, 1, W1, 1,  0, 0, 32'h08, 1, 32'h00, W0);
        vecs[4]  = mk(0, 0, 32'h08, 1, 0, 0,  1,  1, 1, 32'h08, 1, 32'h04, W1);
        vecs[5]  = mk(0, 0, 32'h0E, 1, 1, W2, 0,  1, 1, 32'h0C, 0, 32'h00, 0);
        vecs[6]  = mk(0, 0, 32'h12, 1, 1, W3, 0,  0, 0, 32'h10, 1, 32'h08, W2);
        vecs[7]  = mk(0, 0, 32'h12, 1, 0, 0,  0,  0, 0, 32'h10, 1, 32'h08, W2);
        vecs[8]  = mk(0, 0, 32'h12, 1, 0, 0,  0,  0, 0, 32'h10, 1, 32'h08, W2);
        vecs[9]  = mk(0, 0, 32'h12, 1, 0, 0,  1,  0, 0, 32'h10, 1, 32'h08, W2);
        vecs[10] = mk(0, 0, 32'h12, 1, 0, 0,  1,  1, 1, 32'h10, 1, 32'h0E, W3);
        vecs[11] = mk(0, 0, 32'h16, 1, 1, W4, 1,  1, 1, 32'h14, 0, 32'h00, 0);
        vecs[12] = mk(0, 0, 32'h1A, 1, 1, W5, 1,  0, 0, 32'h18, 1, 32'h12, W4);
        vecs[13] = mk(0, 0, 32'h1A, 1, 0, 0,  1,  1, 1, 32'h18, 1, 32'h16, W5);
        vecs[14] = mk(0, 0, 32'h1E, 0, 0, 0,  1,  1, 0, 32'h1C, 0, 32'h00, 0);
        vecs[15] = mk(0, 0, 32'h1E, 0, 1, W6, 1,  1, 0, 32'h1C, 0, 32'h00, 0);
        vecs[16] = mk(0, 0, 32'h1E, 0, 0, 0,  1,  1, 0, 32'h1C, 1, 32'h1A, W6);

        rst = 1'b1; flush = 1'b0; fetch_pc = '0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, streaming, unaligned PC, IF/ID backpressure and a brief request stall.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].pc, vecs[i].rr,
                  vecs[i].rv, vecs[i].rd, vecs[i].ir);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_adv, vecs[i].e_addr,
                    vecs[i].e_idv, vecs[i].e_pc, vecs[i].e_ins);
            step();
        end

        // Flush with two outstanding and no response: two responses dropped, then refetch at 0x100.
        drive(0, 0, 32'h040, 1, 0, 0, 1);            chk_all("fl2.a1", 1, 1, 32'h040, 0, 0, 0); step();
        drive(0, 0, 32'h044, 1, 0, 0, 1);            chk_all("fl2.a2", 1, 1, 32'h044, 0, 0, 0); step();
        drive(0, 0, 32'h048, 1, 0, 0, 1);            chk_all("fl2.full", 0, 0, 32'h048, 0, 0, 0); step();
        drive(0, 1, 32'h100, 1, 0, 0, 1);            chk_all("fl2.flush", 0, 0, 32'h100, 0, 0, 0); step();
        drive(0, 0, 32'h100, 1, 1, 32'hBAD0_0040, 1); chk_all("fl2.drop1", 0, 0, 32'h100, 0, 0, 0); step();
        drive(0, 0, 32'h100, 1, 1, 32'hBAD0_0044, 1); chk_all("fl2.drop2", 0, 0, 32'h100, 0, 0, 0); step();
        drive(0, 0, 32'h100, 1, 0, 0, 1);            chk_all("fl2.run", 1, 1, 32'h100, 0, 0, 0); step();
        drive(0, 0, 32'h104, 1, 1, 32'h1000_0001, 1); chk_all("fl2.r1", 1, 1, 32'h104, 0, 0, 0); step();
        drive(0, 0, 32'h108, 1, 1, 32'h1000_0002, 0);
        chk_all("fl2.out", 0, 0, 32'h108, 1, 32'h100, 32'h1000_0001); step();

        // Flush coincident with id_ready and a full FIFO: the pop is ignored, FIFO cleared.
        drive(0, 1, 32'h108, 1, 0, 0, 1);
        chk_all("flpop.flush", 0, 0, 32'h108, 1, 32'h100, 32'h1000_0001); step();
        drive(0, 0, 32'h200, 1, 0, 0, 1);            chk_all("flpop.after", 1, 1, 32'h200, 0, 0, 0); step();

        // Flush coincident with the only outstanding response: no drain, no stale instruction.
        drive(0, 1, 32'h300, 1, 1, 32'hBAD0_0200, 1); chk_all("flrsp.flush", 0, 0, 32'h300, 0, 0, 0); step();
        drive(0, 0, 32'h300, 1, 0, 0, 1);            chk_all("flrsp.run", 1, 1, 32'h300, 0, 0, 0); step();
        drive(0, 0, 32'h304, 0, 1, 32'h3000_0001, 1); chk_all("flrsp.rsp", 1, 0, 32'h304, 0, 0, 0); step();

        // imem_req_ready low for 5 cycles: request held with a stable address, no advance.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'h304, 0, 0, 0, 1);
            chk_all($sformatf("stall%0d", i), 1, 0, 32'h304, (i == 0),
                    (i == 0) ? 32'h300 : 32'h0, (i == 0) ? 32'h3000_0001 : 32'h0);
            step();
        end

        // Reset with two outstanding: outputs zero, late responses ignored afterwards.
        drive(0, 0, 32'h304, 1, 0, 0, 1);            chk_all("rst.a1", 1, 1, 32'h304, 0, 0, 0); step();
        drive(0, 0, 32'h308, 1, 0, 0, 1);            chk_all("rst.a2", 1, 1, 32'h308, 0, 0, 0); step();
        drive(1, 0, 32'h000, 1, 0, 0, 1);            chk_all("rst.assert", 0, 0, 32'h000, 0, 0, 0); step();
        drive(1, 0, 32'h000, 1, 1, 32'hBAD0_0304, 1); chk_all("rst.held", 0, 0, 32'h000, 0, 0, 0); step();
        drive(0, 0, 32'h400, 0, 1, 32'hBAD0_0308, 1); chk_all("rst.late", 1, 0, 32'h400, 0, 0, 0); step();
        drive(0, 0, 32'h400, 0, 0, 0, 1);            chk_all("rst.quiet", 1, 0, 32'h400, 0, 0, 0); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
